alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Command-level front end for `alu`. Accepts one arithmetic request at a time (command plus two 8-bit operands) over a valid/ready handshake.
- Sequences the ALU's operand writes and execute ops on the shared 8-bit bus, captures the result from the bus and returns it over a valid/ready response channel.
- Sits between the control unit and the `alu` + `tri_buf` pair. It is the only agent that drives `op`.
- Caches the operand values last written into R0/R1 so it can skip redundant bus writes.

Parameters:
- WIDTH, 8, datapath/bus width; must match `alu`.
- CACHE_EN, 1, 1 = skip a LOAD state when the ALU register already holds the requested operand; 0 = always load.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- n_reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_cmd  in  2  0=ADD (a+b), 1=SUB (a-b), 2=INC (b+1), 3=PASS (returns a).
- req_a  in  WIDTH  operand for R0.
- req_b  in  WIDTH  operand for R1.
- op  out  alu_op_t  ALU operation, registered.
- bus_oe  out  1  drives `tri_buf` rw; 1 = sequencer drives the bus.
- bus_out  out  WIDTH  value driven when bus_oe=1; feeds `tri_buf` data.
- bus_in  in  WIDTH  observed bus value.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  result, held stable while rsp_valid=1.

Behaviour:
- Reset (async, any state) forces:
  - state=IDLE, op=ALU_NOP, bus_oe=0, bus_out=0, rsp_valid=0, rsp_data=0.
  - r0_cache_vld=0, r1_cache_vld=0.
  - Same n_reset as `alu`, so the cache and the ALU registers are invalidated together.
- States: IDLE, LOAD_R0, LOAD_R1, EXEC, RESP. All outputs are registered and follow the state.
- Request handshake:
  - req_ready=1 only in IDLE (decoded from state, not from req_valid).
  - Accept on posedge with req_valid & req_ready; latch cmd, a, b.
  - Inputs are ignored in every other state.
- Load-step selection at accept:
  - need_r0 = cmd!=INC and !(CACHE_EN & r0_cache_vld & r0_cache==a).
  - need_r1 = cmd in {ADD,SUB,INC} and !(CACHE_EN & r1_cache_vld & r1_cache==b).
  - Next state is the first of LOAD_R0 (if need_r0), LOAD_R1 (if need_r1), else EXEC.
- LOAD_R0: op=ALU_WRITE_R0, bus_oe=1, bus_out=a. On exit set r0_cache=a, r0_cache_vld=1. Go to LOAD_R1 if need_r1, else EXEC.
- LOAD_R1: op=ALU_WRITE_R1, bus_oe=1, bus_out=b. On exit set r1_cache=b, r1_cache_vld=1. Go to EXEC.
- EXEC:
  - bus_oe=0, so the ALU drives the bus.
  - op = ALU_ADD / ALU_SUB / ALU_INC / ALU_READ_R0 for cmd 0/1/2/3.
  - At the closing posedge: rsp_data<=bus_in, rsp_valid<=1, go to RESP.
- RESP:
  - op=ALU_NOP, bus_oe=0.
  - Hold rsp_valid and rsp_data until rsp_ready=1 at a posedge, then rsp_valid<=0 and go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Bus exclusivity:
  - bus_oe=1 only in LOAD_R0/LOAD_R1.
  - op is never a bus-driving ALU op (ADD/SUB/INC/READ_*) while bus_oe=1.
  - bus_oe=0 in all other states, so no contention.
- Latency, request-accept edge to rsp_valid rising:
  - 1 cycle per LOAD state performed, plus 1 for EXEC.
  - ADD/SUB with no hits: 3 cycles. INC with no hit: 2. PASS with no hit: 2. Full cache hit: 1.
- Arithmetic is the ALU's: modulo 2^WIDTH, no carry/borrow output. 0xFF+1 returns 0x00; 0x00-0x01 returns 0xFF.
- Back-to-back requests: minimum issue interval = latency + 1 (RESP) + 1 (IDLE).
- Reset mid-operation (for example during LOAD_R1):
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - The pending request and response are dropped.
  - The next request after release performs full loads (cache invalid).
- With CACHE_EN=0 the cache registers still exist but the compare is forced false.

Test Plan:
- Reset: hold n_reset=0 and pulse it low mid-EXEC -> op=ALU_NOP, bus_oe=0, rsp_valid=0, req_ready=0 while n_reset=0, and req_ready=1 on the first cycle after release.
- ADD 1,5 after reset -> op sequence WRITE_R0, WRITE_R1, ADD; bus_out 1 then 5; rsp_valid rises 3 cycles after accept; rsp_data=6.
- SUB 5,3 -> 2. Then SUB 0,1 -> 0xFF. Then ADD 0xFF,1 -> 0x00 (modulo wrap).
- Cache: ADD 1,5 then ADD 1,7 -> the second request skips LOAD_R0, latency 2, result 8. Then ADD 1,7 again -> EXEC only, latency 1, result 8. Repeat with CACHE_EN=0 -> latency always 3.
- INC 1 -> no WRITE_R0 cycle, rsp_data=2. PASS 15 -> WRITE_R0 then READ_R0, rsp_data=15.
- Backpressure: hold rsp_ready=0 for 4 cycles -> rsp_valid and rsp_data stable, req_ready=0, op=ALU_NOP, bus_oe=0 throughout. Release -> one handshake, then IDLE.

Source files
------------

// File: rtl/alu_sequencer.sv
// Command-level front end for the shared-bus ALU: sequences operand writes and the execute op,
// captures the result from the bus, and caches the operand values last written to R0/R1.

typedef enum logic [2:0] {
  ALU_NOP      = 3'd0,
  ALU_WRITE_R0 = 3'd1,
  ALU_WRITE_R1 = 3'd2,
  ALU_READ_R0  = 3'd3,
  ALU_READ_R1  = 3'd4,
  ALU_ADD      = 3'd5,
  ALU_SUB      = 3'd6,
  ALU_INC      = 3'd7
} alu_op_t;

module alu_sequencer #(
  parameter int WIDTH    = 8,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_cmd,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output alu_op_t          op,
  output logic             bus_oe,
  output logic [WIDTH-1:0] bus_out,
  input  logic [WIDTH-1:0] bus_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data
);

  typedef enum logic [2:0] {IDLE, LOAD_R0, LOAD_R1, EXEC, RESP} state_t;

  localparam logic [1:0] CMD_ADD  = 2'd0;
  localparam logic [1:0] CMD_SUB  = 2'd1;
  localparam logic [1:0] CMD_INC  = 2'd2;
  localparam logic [1:0] CMD_PASS = 2'd3;

  state_t           state, state_nxt;
  alu_op_t          op_nxt;
  logic             bus_oe_nxt;
  logic [WIDTH-1:0] bus_out_nxt;

  logic [1:0]       cmd_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             need_r1_q;

  logic [WIDTH-1:0] r0_cache, r1_cache;
  logic             r0_cache_vld, r1_cache_vld;

  logic accept, r0_hit, r1_hit, need_r0, need_r1;

  function automatic alu_op_t exec_op(input logic [1:0] cmd);
    case (cmd)
      CMD_ADD: exec_op = ALU_ADD;
      CMD_SUB: exec_op = ALU_SUB;
      CMD_INC: exec_op = ALU_INC;
      default: exec_op = ALU_READ_R0;
    endcase
  endfunction

  // Ready is withheld while reset is asserted even though the state already reads IDLE.
  assign req_ready = (state == IDLE) && n_reset;
  assign accept    = req_valid && (state == IDLE);

  assign r0_hit  = CACHE_EN && r0_cache_vld && (r0_cache == req_a);
  assign r1_hit  = CACHE_EN && r1_cache_vld && (r1_cache == req_b);
  assign need_r0 = (req_cmd != CMD_INC) && !r0_hit;
  assign need_r1 = (req_cmd != CMD_PASS) && !r1_hit;

  always_comb begin
    state_nxt   = state;
    op_nxt      = ALU_NOP;
    bus_oe_nxt  = 1'b0;
    bus_out_nxt = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (need_r0) begin
            state_nxt   = LOAD_R0;
            op_nxt      = ALU_WRITE_R0;
            bus_oe_nxt  = 1'b1;
            bus_out_nxt = req_a;
          end else if (need_r1) begin
            state_nxt   = LOAD_R1;
            op_nxt      = ALU_WRITE_R1;
            bus_oe_nxt  = 1'b1;
            bus_out_nxt = req_b;
          end else begin
            state_nxt = EXEC;
            op_nxt    = exec_op(req_cmd);
          end
        end
      end
      LOAD_R0: begin
        if (need_r1_q) begin
          state_nxt   = LOAD_R1;
          op_nxt      = ALU_WRITE_R1;
          bus_oe_nxt  = 1'b1;
          bus_out_nxt = b_q;
        end else begin
          state_nxt = EXEC;
          op_nxt    = exec_op(cmd_q);
        end
      end
      LOAD_R1: begin
        state_nxt = EXEC;
        op_nxt    = exec_op(cmd_q);
      end
      EXEC: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered alongside the state so they always describe the current state.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      op      <= ALU_NOP;
      bus_oe  <= 1'b0;
      bus_out <= '0;
    end else begin
      state   <= state_nxt;
      op      <= op_nxt;
      bus_oe  <= bus_oe_nxt;
      bus_out <= bus_out_nxt;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cmd_q     <= CMD_ADD;
      a_q       <= '0;
      b_q       <= '0;
      need_r1_q <= 1'b0;
    end else if (accept) begin
      cmd_q     <= req_cmd;
      a_q       <= req_a;
      b_q       <= req_b;
      need_r1_q <= need_r1;
    end
  end

  // The cache follows the ALU registers, which capture the bus on the edge leaving a LOAD state.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r0_cache     <= '0;
      r1_cache     <= '0;
      r0_cache_vld <= 1'b0;
      r1_cache_vld <= 1'b0;
    end else begin
      if (state == LOAD_R0) begin
        r0_cache     <= a_q;
        r0_cache_vld <= 1'b1;
      end
      if (state == LOAD_R1) begin
        r1_cache     <= b_q;
        r1_cache_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= bus_in;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
